// File: rtl/fifo_mac_pkg.sv
// Shared types and sizing helpers for the FIFO-fed dot-product accumulator.
package fifo_mac_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mac_state_t;

    localparam int WORD_W     = 64;
    localparam int LANES_DEF  = 4;
    localparam int LANE_W_DEF = 16;
    localparam int ACC_W_DEF  = 48;

    // Width of one dot product: full-width lane products plus adder-tree growth.
    function automatic int dot_w(input int lanes, input int lane_w);
        return 2 * lane_w + $clog2(lanes);
    endfunction

endpackage

// File: rtl/fifo_mac_unit_dot.sv
// Combinational signed LANES-way multiply and reduction of one data word against the weights.
module fifo_mac_unit_dot #(
    parameter int LANES  = 4,
    parameter int LANE_W = 16,
    parameter int DOT_W  = 34
) (
    input  logic [LANES*LANE_W-1:0] x_i,
    input  logic [LANES*LANE_W-1:0] w_i,
    output logic signed [DOT_W-1:0] dot_o
);

    logic signed [2*LANE_W-1:0] prod [LANES];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        // Widen before multiplying so the full product is kept.
        assign prod[gi] = (2*LANE_W)'($signed(x_i[gi*LANE_W +: LANE_W]))
                        * (2*LANE_W)'($signed(w_i[gi*LANE_W +: LANE_W]));
    end

    always_comb begin
        dot_o = '0;
        for (int i = 0; i < LANES; i++) begin
            dot_o = dot_o + DOT_W'(prod[i]);
        end
    end

endmodule

// File: rtl/fifo_mac_unit.sv
// Pops words from the MMIO write FIFO, dots them with the weight word and accumulates
// a programmed number of products; the sum is held for MMIO readback.
module fifo_mac_unit
    import fifo_mac_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int LANE_W = LANE_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wt_we_i,
    input  logic [63:0]       wt_data_i,
    input  logic              start_i,
    input  logic [15:0]       len_i,
    input  logic              in_valid_i,
    input  logic [63:0]       in_data_i,
    output logic              in_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [ACC_W-1:0]  result_o
);

    localparam int DOT_W = dot_w(LANES, LANE_W);

    if (LANES * LANE_W != WORD_W) begin : g_bad_packing
        $error("fifo_mac_unit: LANES*LANE_W must equal 64");
    end

    mac_state_t              state_q, state_d;
    logic [63:0]             wt_q;
    logic [15:0]             len_q, cnt_q;
    logic signed [DOT_W-1:0] dot_c, dot_q;
    logic                    s1_vld_q;
    logic [ACC_W-1:0]        acc_q, acc_sum, dot_ext;
    logic                    ovf_q, ovf_now;
    logic                    accept, idle_like, clear;

    fifo_mac_unit_dot #(.LANES(LANES), .LANE_W(LANE_W), .DOT_W(DOT_W)) u_dot (
        .x_i   (in_data_i),
        .w_i   (wt_q),
        .dot_o (dot_c)
    );

    assign in_ready_o = (state_q == RUN);
    assign busy_o     = (state_q == RUN) || (state_q == DRAIN);
    assign done_o     = (state_q == DONE);
    assign overflow_o = ovf_q;
    assign result_o   = acc_q;

    assign accept    = in_valid_i & in_ready_o;
    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign clear     = idle_like & start_i;

    // Sign-extends, or truncates when the accumulator is narrower than a dot product.
    assign dot_ext = ACC_W'(dot_q);
    assign acc_sum = acc_q + dot_ext;
    assign ovf_now = (acc_q[ACC_W-1] == dot_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_i) state_d = (len_i != 16'd0) ? RUN : DONE;
            RUN:        if (accept && cnt_q == len_q - 16'd1) state_d = DRAIN;
            DRAIN:      if (!s1_vld_q) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wt_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            dot_q    <= '0;
            s1_vld_q <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_vld_q <= accept;
            if (wt_we_i && idle_like) wt_q <= wt_data_i;
            if (accept) dot_q <= dot_c;
            if (clear) begin
                len_q <= len_i;
                cnt_q <= '0;
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (accept) cnt_q <= cnt_q + 16'd1;
                if (s1_vld_q) begin
                    acc_q <= acc_sum;
                    ovf_q <= ovf_q | ovf_now;
                end
            end
        end
    end

endmodule
